// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: address/data widths,
// byte-mask type and the FSM state encoding.
package DEF;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_BYTES  = 8;

    typedef logic [63:0]           dw;
    typedef logic [MEM_ADDR_W-1:0] addr_t;
    typedef logic [MEM_BYTES-1:0]  mask_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    // Address of byte idx of an access; wraps modulo 2^MEM_ADDR_W.
    function automatic addr_t byte_addr(input addr_t base, input logic [2:0] idx);
        return base + addr_t'(idx);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator (master) and the
// memory responder (slave).
interface mem_responder_if;
    import DEF::*;

    logic  req_valid;
    logic  req_ready;
    addr_t req_addr;
    mask_t req_w_mask;
    dw     req_wdata;
    logic  resp_valid;
    logic  resp_ready;
    dw     resp_rdata;
    logic  resp_was_write;

    modport slave (
        input  req_valid, req_addr, req_w_mask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_was_write
    );

    modport master (
        output req_valid, req_addr, req_w_mask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_was_write
    );

endinterface

// File: rtl/mem_byte_array.sv
// 64 KiB byte store: combinational 8-byte read at a wrapping address and a
// byte-masked synchronous write at the same address.
module mem_byte_array
    import DEF::*;
(
    input  logic  clk,
    input  addr_t i_addr,
    input  mask_t i_wmask,
    input  dw     i_wdata,
    output dw     o_rdata
);

    // NOTE: storage has no reset branch on purpose; a RAM cannot be cleared
    // in one cycle, and contents must survive rst.
    logic [7:0] r_mem [0:(2**MEM_ADDR_W)-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            o_rdata[8*i +: 8] = r_mem[byte_addr(i_addr, 3'(i))];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (i_wmask[i]) begin
                r_mem[byte_addr(i_addr, 3'(i))] <= i_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, performs a read-before-write access and holds the response.
module mem_responder
    import DEF::*;
#(
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_responder_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_resp_state_t r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    addr_t           r_addr;
    mask_t           r_mask;
    dw               r_wdata;
    dw               r_rdata;
    logic            r_was_write;

    logic  w_accept;
    logic  w_enter_resp;
    addr_t w_acc_addr;
    mask_t w_acc_mask;
    mask_t w_mem_wmask;
    dw     w_acc_wdata;
    dw     w_mem_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_nxt    = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge, before the latches load.
    assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr   : r_addr;
    assign w_acc_mask  = (r_state == IDLE) ? bus.req_w_mask : r_mask;
    assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata  : r_wdata;
    assign w_mem_wmask = (w_enter_resp && !rst) ? w_acc_mask : '0;

    mem_byte_array u_mem (
        .clk     (clk),
        .i_addr  (w_acc_addr),
        .i_wmask (w_mem_wmask),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which is what makes read-before-write work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_was_write <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_mask  <= bus.req_w_mask;
                r_wdata <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata     <= w_mem_rdata;
                r_was_write <= |w_acc_mask;
            end
        end
    end

    assign bus.req_ready      = (r_state == IDLE);
    assign bus.resp_valid     = (r_state == RESP);
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_was_write = r_was_write;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at
// LATENCY=1; sel picks which instance the shared stimulus drives.
module tb_mem_responder;
    import DEF::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if if_a ();
    mem_responder_if if_b ();

    mem_responder #(.LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mem_responder #(.LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    logic  sel;
    logic  d_req_valid;
    logic  d_resp_ready;
    addr_t d_addr;
    mask_t d_mask;
    dw     d_wdata;

    assign if_a.req_valid  = d_req_valid & ~sel;
    assign if_b.req_valid  = d_req_valid & sel;
    assign if_a.resp_ready = d_resp_ready & ~sel;
    assign if_b.resp_ready = d_resp_ready & sel;
    assign if_a.req_addr   = d_addr;
    assign if_b.req_addr   = d_addr;
    assign if_a.req_w_mask = d_mask;
    assign if_b.req_w_mask = d_mask;
    assign if_a.req_wdata  = d_wdata;
    assign if_b.req_wdata  = d_wdata;

    logic w_req_ready, w_resp_valid, w_resp_was_write;
    dw    w_resp_rdata;
    assign w_req_ready      = sel ? if_b.req_ready      : if_a.req_ready;
    assign w_resp_valid     = sel ? if_b.resp_valid     : if_a.resp_valid;
    assign w_resp_rdata     = sel ? if_b.resp_rdata     : if_a.resp_rdata;
    assign w_resp_was_write = sel ? if_b.resp_was_write : if_a.resp_was_write;

    int n_checks = 0;
    int n_fail   = 0;

    // Full transaction starting and ending at a negedge; checks response latency.
    task automatic access(input string name, input addr_t a, input mask_t m, input dw wd,
                          input int exp_lat, output dw rd, output logic ww);
        int n;
        int lat;
        d_addr = a; d_mask = m; d_wdata = wd; d_req_valid = 1'b1; d_resp_ready = 1'b0;
        n = 0;
        while (!w_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        lat = 1;
        while (!w_resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        rd = w_resp_rdata;
        ww = w_resp_was_write;
        d_resp_ready = 1'b1;
        @(negedge clk);
        d_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_checks++;
            if (w_req_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset req_ready dut%0d: got %b expected 1", s, w_req_ready);
            end
            n_checks++;
            if (w_resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset resp_valid dut%0d: got %b expected 0", s, w_resp_valid);
            end
            n_checks++;
            if (w_resp_rdata !== 64'h0) begin
                n_fail++; $display("FAIL reset resp_rdata dut%0d: got %h expected 0", s, w_resp_rdata);
            end
            n_checks++;
            if (w_resp_was_write !== 1'b0) begin
                n_fail++; $display("FAIL reset was_write dut%0d: got %b expected 0", s, w_resp_was_write);
            end
        end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        dw rd;
        logic ww;
        access("wr_0010", 16'h0010, 8'hFF, 64'h1122334455667788, 2, rd, ww);
        n_checks++;
        if (ww !== 1'b1) begin
            n_fail++; $display("FAIL wr_0010 was_write: got %b expected 1", ww);
        end
        access("rd_0010", 16'h0010, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL rd_0010 rdata: got %h expected 1122334455667788", rd);
        end
        n_checks++;
        if (ww !== 1'b0) begin
            n_fail++; $display("FAIL rd_0010 was_write: got %b expected 0", ww);
        end
    endtask

    task automatic test_read_before_write();
        dw rd;
        logic ww;
        access("fill_0020", 16'h0020, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 2, rd, ww);
        access("rbw_0020", 16'h0020, 8'h01, 64'h1111111111111155, 2, rd, ww);
        n_checks++;
        if (rd !== 64'hAAAAAAAAAAAAAAAA) begin
            n_fail++; $display("FAIL rbw old data: got %h expected aaaaaaaaaaaaaaaa", rd);
        end
        access("rd_0020", 16'h0020, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd !== 64'hAAAAAAAAAAAAAA55) begin
            n_fail++; $display("FAIL rbw new data: got %h expected aaaaaaaaaaaaaa55", rd);
        end
    endtask

    task automatic test_wrap();
        dw rd;
        logic ww;
        access("wr_fffd", 16'hFFFD, 8'hFF, 64'h0807060504030201, 2, rd, ww);
        access("rd_0000", 16'h0000, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd[39:0] !== 40'h0807060504) begin
            n_fail++; $display("FAIL wrap low bytes: got %h expected 0807060504", rd[39:0]);
        end
        access("rd_fffd", 16'hFFFD, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd !== 64'h0807060504030201) begin
            n_fail++; $display("FAIL wrap read: got %h expected 0807060504030201", rd);
        end
    endtask

    task automatic test_backpressure();
        dw rd;
        logic ww;
        int lat;
        access("wr_0030", 16'h0030, 8'hFF, 64'h0123456789ABCDEF, 2, rd, ww);
        d_addr = 16'h0030; d_mask = 8'h00; d_wdata = 64'h0; d_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        lat = 1;
        while (!w_resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        // A competing write arrives while the response is stalled; it must be ignored.
        d_mask = 8'hFF; d_wdata = 64'hDEADBEEFDEADBEEF; d_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (w_resp_valid !== 1'b1 || w_resp_rdata !== 64'h0123456789ABCDEF ||
                w_req_ready !== 1'b0 || w_resp_was_write !== 1'b0) begin
                n_fail++;
                $display("FAIL stall cycle %0d: valid=%b rdata=%h ready=%b ww=%b expected 1/0123456789abcdef/0/0",
                         c, w_resp_valid, w_resp_rdata, w_req_ready, w_resp_was_write);
            end
            @(negedge clk);
        end
        d_req_valid = 1'b0;
        d_resp_ready = 1'b1;
        @(negedge clk);
        d_resp_ready = 1'b0;
        n_checks++;
        if (w_resp_valid !== 1'b0 || w_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall release: valid=%b ready=%b expected 0/1", w_resp_valid, w_req_ready);
        end
        access("rd_0030", 16'h0030, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL ignored write: got %h expected 0123456789abcdef", rd);
        end
    endtask

    task automatic test_reset_in_wait();
        dw rd;
        logic ww;
        access("wr_0040", 16'h0040, 8'hFF, 64'h5555555555555555, 2, rd, ww);
        d_addr = 16'h0040; d_mask = 8'hFF; d_wdata = 64'h9999999999999999; d_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        n_checks++;
        if (w_req_ready !== 1'b0 || w_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait state: ready=%b valid=%b expected 0/0", w_req_ready, w_resp_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (w_resp_valid !== 1'b0 || w_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL async reset: valid=%b ready=%b expected 0/1", w_resp_valid, w_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (w_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL after reset resp_valid: got %b expected 0", w_resp_valid);
        end
        access("rd_0040", 16'h0040, 8'h00, 64'h0, 2, rd, ww);
        n_checks++;
        if (rd !== 64'h5555555555555555) begin
            n_fail++; $display("FAIL dropped write: got %h expected 5555555555555555", rd);
        end
    endtask

    task automatic test_latency1();
        dw rd;
        logic ww;
        int prev;
        int accepts;
        sel = 1'b1;
        #1;
        access("l1_wr", 16'h1234, 8'hFF, 64'hCAFEF00D12345678, 1, rd, ww);
        n_checks++;
        if (ww !== 1'b1) begin
            n_fail++; $display("FAIL l1_wr was_write: got %b expected 1", ww);
        end
        access("l1_rd", 16'h1234, 8'h00, 64'h0, 1, rd, ww);
        n_checks++;
        if (rd !== 64'hCAFEF00D12345678) begin
            n_fail++; $display("FAIL l1_rd rdata: got %h expected cafef00d12345678", rd);
        end
        // Continuous requests with response always accepted: one accept every 2 cycles.
        d_addr = 16'h1234; d_mask = 8'h00; d_req_valid = 1'b1; d_resp_ready = 1'b1;
        prev = -1;
        accepts = 0;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (w_resp_valid !== ~w_req_ready) begin
                n_fail++; $display("FAIL b2b cycle %0d: valid=%b ready=%b expected complementary",
                                   c, w_resp_valid, w_req_ready);
            end
            if (w_req_ready === 1'b1) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (c - prev !== 2) begin
                        n_fail++; $display("FAIL b2b spacing: got %0d expected 2", c - prev);
                    end
                end
                prev = c;
                accepts++;
            end
            @(negedge clk);
        end
        d_req_valid = 1'b0;
        d_resp_ready = 1'b0;
        n_checks++;
        if (accepts !== 5) begin
            n_fail++; $display("FAIL b2b accept count: got %0d expected 5", accepts);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel          = 1'b0;
        d_req_valid  = 1'b0;
        d_resp_ready = 1'b0;
        d_addr       = '0;
        d_mask       = '0;
        d_wdata      = '0;
        test_reset();
        test_write_read();
        test_read_before_write();
        test_wrap();
        test_backpressure();
        test_reset_in_wait();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
